// File: rtl/rr_lock_mux_if.sv
// rtl/rr_lock_mux_if.sv - request and output stream bundle for rr_lock_mux
// Ports (signals):
//   din_valid/din_ready/din_eot [SIZE]  per-channel handshake and last-beat flag
//   din_data [SIZE*WIDTH]               channel i at [i*WIDTH +: WIDTH]
//   dout_valid/dout_ready/dout_eot      shared downstream handshake and last-beat flag
//   dout_data [WIDTH], dout_ctrl [CW]   output beat and its source channel index
// Modports: slave = the mux itself, master = the producers/consumer around it.
interface rr_lock_mux_if #(
   parameter int SIZE  = 2,
   parameter int WIDTH = 16
);
   localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

   logic [SIZE-1:0]       din_valid;
   logic [SIZE-1:0]       din_ready;
   logic [SIZE*WIDTH-1:0] din_data;
   logic [SIZE-1:0]       din_eot;
   logic                  dout_valid;
   logic                  dout_ready;
   logic [WIDTH-1:0]      dout_data;
   logic                  dout_eot;
   logic [CW-1:0]         dout_ctrl;

   modport slave (
      input  din_valid, din_data, din_eot, dout_ready,
      output din_ready, dout_valid, dout_data, dout_eot, dout_ctrl
   );

   modport master (
      output din_valid, din_data, din_eot, dout_ready,
      input  din_ready, dout_valid, dout_data, dout_eot, dout_ctrl
   );
endinterface

// File: rtl/rr_lock_mux.sv
// rtl/rr_lock_mux.sv - round-robin packet-locking fan-in mux with registered output
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  rr_lock_mux_if.slave: SIZE request streams in, one tagged stream out
// Parameters: SIZE channels, WIDTH data bits, LOCK=1 holds the grant until an eot beat.
module rr_lock_mux #(
   parameter int SIZE  = 2,
   parameter int WIDTH = 16,
   parameter int LOCK  = 1
) (
   input logic          clk,
   input logic          rst,
   rr_lock_mux_if.slave bus
);
   localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

   logic [CW-1:0]    ptr;
   logic             locked;
   logic [CW-1:0]    lock_idx;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_eot;
   logic [CW-1:0]    out_ctrl;

   logic             load;
   logic             win_found;
   logic [CW-1:0]    win_idx;
   logic [CW-1:0]    ptr_nxt;
   logic [WIDTH-1:0] win_data;
   logic             win_eot;
   logic [SIZE-1:0]  ready_vec;

   assign load = !out_valid || bus.dout_ready;

   // Scan from the far end back towards ptr so the last hit is the first
   // valid channel in round-robin order starting at ptr.
   always_comb begin
      int cand;
      cand      = 0;
      win_found = 1'b0;
      win_idx   = '0;
      if (locked) begin
         win_found = bus.din_valid[lock_idx];
         win_idx   = lock_idx;
      end else begin
         for (int k = SIZE - 1; k >= 0; k--) begin
            cand = int'(ptr) + k;
            if (cand >= SIZE) cand = cand - SIZE;
            if (bus.din_valid[cand]) begin
               win_found = 1'b1;
               win_idx   = CW'(cand);
            end
         end
      end
   end

   assign ptr_nxt  = (int'(win_idx) == SIZE - 1) ? '0 : win_idx + 1'b1;
   assign win_data = bus.din_data[win_idx*WIDTH +: WIDTH];
   assign win_eot  = bus.din_eot[win_idx];

   always_comb begin
      ready_vec = '0;
      if (rst && load && win_found) ready_vec[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr       <= '0;
         locked    <= 1'b0;
         lock_idx  <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_eot   <= 1'b0;
         out_ctrl  <= '0;
      end else if (load) begin
         if (win_found) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_eot   <= win_eot;
            out_ctrl  <= win_idx;
            if (LOCK != 0 && !win_eot) begin
               locked   <= 1'b1;
               lock_idx <= win_idx;
            end else begin
               locked <= 1'b0;
               ptr    <= ptr_nxt;
            end
         end else begin
            // A locked channel that stalls leaves a bubble; the grant is kept.
            out_valid <= 1'b0;
         end
      end
   end

   assign bus.din_ready  = ready_vec;
   assign bus.dout_valid = out_valid;
   assign bus.dout_data  = out_data;
   assign bus.dout_eot   = out_eot;
   assign bus.dout_ctrl  = out_ctrl;
endmodule
